inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 162 ++++++++++++++++
 tb/tb_inst_fetch.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Purpose:
//   Single-outstanding instruction fetch unit. A PC handed over by the
//   upstream address generator is issued as one AXI4-Lite read. The returned
//   word is then presented to decode together with its PC and an error flag.
//   A redirect (flush_i) kills whatever fetch is in flight. A read that has
//   already been issued cannot be withdrawn, so its response is drained
//   silently before a new PC is accepted.
//
// Ports:
//   clock          in   1   rising-edge clock
//   reset          in   1   synchronous, active-high reset
//   valid_pre_i    in   1   upstream holds a valid fetch PC
//   ready_pre_o    out  1   unit can accept a PC (only when idle)
//   pc_i           in   32  fetch address from upstream
//   flush_i        in   1   redirect, kills any fetch in flight
//   arvalid_o      out  1   AXI read-address valid
//   arready_i      in   1   AXI read-address ready
//   araddr_o       out  32  AXI read address (latched PC)
//   rvalid_i       in   1   AXI read-data valid
//   rready_o       out  1   AXI read-data ready
//   rdata_i        in   32  AXI read data
//   rresp_i        in   2   AXI read response (non-zero = error)
//   valid_post_o   out  1   fetched instruction available to decode
//   ready_post_i   in   1   decode accepts the instruction
//   pc_o           out  32  PC of the delivered fetch
//   inst_o         out  32  instruction word (NOP on a bus error)
//   inst_err_o     out  1   delivered fetch had a bus error
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] ERR_INST = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_pre_i,
  output logic        ready_pre_o,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        arvalid_o,
  input  logic        arready_i,
  output logic [31:0] araddr_o,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  output logic        valid_post_o,
  input  logic        ready_post_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_AR,
    WAIT_R,
    WAIT_READY
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_discard;
  logic        w_nextDiscard;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_instErr;
  logic        w_accept;
  logic        w_capture;

  // State and discard-flag register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_discard <= w_nextDiscard;
    end
  end

  // Next-state logic. The discard flag records that the read in flight
  // belongs to a killed fetch; being a single bit, any number of flushes
  // still leaves exactly one response to drain.
  always_comb begin
    w_nextState   = r_state;
    w_nextDiscard = r_discard;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (valid_pre_i && !flush_i) begin
          w_accept    = 1'b1;
          w_nextState = WAIT_AR;
        end
      end
      WAIT_AR: begin
        // The address beat cannot be withdrawn once offered, so a flush
        // here only marks the eventual response for discarding.
        if (flush_i) begin
          w_nextDiscard = 1'b1;
        end
        if (arready_i) begin
          w_nextState = WAIT_R;
        end
      end
      WAIT_R: begin
        if (rvalid_i) begin
          if (flush_i || r_discard) begin
            w_nextState   = IDLE;
            w_nextDiscard = 1'b0;
          end else begin
            w_capture   = 1'b1;
            w_nextState = WAIT_READY;
          end
        end else if (flush_i) begin
          w_nextDiscard = 1'b1;
        end
      end
      WAIT_READY: begin
        if (flush_i || ready_post_i) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState   = IDLE;
        w_nextDiscard = 1'b0;
      end
    endcase
  end

  // Fetch datapath: the PC is captured on accept and the instruction on
  // the read beat. Neither changes while a delivery is pending, which keeps
  // araddr_o and the decode-side outputs stable without extra muxing.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc      <= 32'h0;
      r_inst    <= 32'h0;
      r_instErr <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pc <= pc_i;
      end
      if (w_capture) begin
        r_inst    <= (rresp_i != 2'b00) ? ERR_INST : rdata_i;
        r_instErr <= (rresp_i != 2'b00);
      end
    end
  end

  // Handshake outputs decode directly from the state.
  assign ready_pre_o  = (r_state == IDLE);
  assign arvalid_o    = (r_state == WAIT_AR);
  assign rready_o     = (r_state == WAIT_R);
  assign valid_post_o = (r_state == WAIT_READY);
  assign araddr_o     = r_pc;
  assign pc_o         = r_pc;
  assign inst_o       = r_inst;
  assign inst_err_o   = r_instErr;

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//
// Directed bench for inst_fetch. The bench plays the AXI slave and the
// decode stage. Each fetch that should reach decode is pushed into a
// scoreboard when its read beat is driven, and is popped and compared when
// valid_post_o appears.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } fetch_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_pre_i;
  logic        ready_pre_o;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] araddr_o;
  logic        rvalid_i;
  logic        rready_o;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        valid_post_o;
  logic        ready_post_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_err_o;

  fetch_t sb[$];
  int     nChecks = 0;
  int     nFails  = 0;

  inst_fetch dut (
    .clock        (clock),
    .reset        (reset),
    .valid_pre_i  (valid_pre_i),
    .ready_pre_o  (ready_pre_o),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .arvalid_o    (arvalid_o),
    .arready_i    (arready_i),
    .araddr_o     (araddr_o),
    .rvalid_i     (rvalid_i),
    .rready_o     (rready_o),
    .rdata_i      (rdata_i),
    .rresp_i      (rresp_i),
    .valid_post_o (valid_post_o),
    .ready_post_i (ready_post_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_err_o   (inst_err_o)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Advance one clock edge; outputs are then sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare a delivered fetch against the oldest scoreboard entry.
  task automatic checkDelivery(input string tag);
    fetch_t exp;
    checkOutput({tag, "_valid"}, valid_post_o, 1);
    checkOutput({tag, "_sbPending"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      checkOutput({tag, "_pc"}, pc_o, exp.pc);
      checkOutput({tag, "_inst"}, inst_o, exp.inst);
      checkOutput({tag, "_err"}, inst_err_o, exp.err);
    end
  endtask

  // Best-case fetch: accept, immediate arready, read beat the next cycle.
  // Leaves the DUT presenting the result to decode.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] data,
                               input logic [1:0] resp);
    fetch_t exp;
    valid_pre_i = 1'b1;
    pc_i        = pc;
    tick();
    valid_pre_i = 1'b0;
    checkOutput("arvalid_N1", arvalid_o, 1);
    checkOutput("araddr_N1", araddr_o, pc);
    checkOutput("readyPre_N1", ready_pre_o, 0);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    checkOutput("rready_N2", rready_o, 1);
    checkOutput("arvalid_N2", arvalid_o, 0);
    rvalid_i = 1'b1;
    rdata_i  = data;
    rresp_i  = resp;
    exp.pc   = pc;
    exp.inst = (resp != 2'b00) ? NOP : data;
    exp.err  = (resp != 2'b00);
    sb.push_back(exp);
    tick();
    rvalid_i = 1'b0;
    rresp_i  = 2'b00;
  endtask

  // Decode takes the pending instruction; the unit must return to idle.
  task automatic acceptDelivery(input string tag);
    ready_post_i = 1'b1;
    tick();
    ready_post_i = 1'b0;
    checkOutput({tag, "_validDrop"}, valid_post_o, 0);
    checkOutput({tag, "_idle"}, ready_pre_o, 1);
  endtask

  initial begin
    reset        = 1'b1;
    valid_pre_i  = 1'b0;
    pc_i         = 32'h0;
    flush_i      = 1'b0;
    arready_i    = 1'b0;
    rvalid_i     = 1'b0;
    rdata_i      = 32'h0;
    rresp_i      = 2'b00;
    ready_post_i = 1'b0;

    // Reset values.
    tick();
    tick();
    checkOutput("rst_arvalid", arvalid_o, 0);
    checkOutput("rst_rready", rready_o, 0);
    checkOutput("rst_validPost", valid_post_o, 0);
    checkOutput("rst_pc", pc_o, 0);
    checkOutput("rst_inst", inst_o, 0);
    checkOutput("rst_err", inst_err_o, 0);
    reset = 1'b0;
    tick();
    checkOutput("rst_readyPre", ready_pre_o, 1);

    // Best-case fetch with N+3 latency.
    $display("[TB] best-case fetch");
    applyStimulus(32'h8000_0000, 32'h0010_0093, 2'b00);
    checkDelivery("best");
    acceptDelivery("best");

    // Decode stalls for 5 cycles: outputs must hold.
    $display("[TB] decode stall");
    applyStimulus(32'h8000_0004, 32'h0020_0113, 2'b00);
    checkDelivery("stall");
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", valid_post_o, 1);
      checkOutput("stall_pc", pc_o, 32'h8000_0004);
      checkOutput("stall_inst", inst_o, 32'h0020_0113);
      checkOutput("stall_readyPre", ready_pre_o, 0);
      tick();
    end
    acceptDelivery("stall");

    // Flush in WAIT_AR with arready delayed 3 cycles, plus a repeated
    // flush while waiting for the response: exactly one beat is drained.
    $display("[TB] flush while address pending");
    valid_pre_i = 1'b1;
    pc_i        = 32'h8000_0008;
    tick();
    valid_pre_i = 1'b0;
    pc_i        = 32'hFFFF_FFFC;
    flush_i     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("flAr_arvalid", arvalid_o, 1);
      checkOutput("flAr_araddr", araddr_o, 32'h8000_0008);
      checkOutput("flAr_validPost", valid_post_o, 0);
      tick();
      flush_i = 1'b0;
    end
    checkOutput("flAr_arvalidHeld", arvalid_o, 1);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    checkOutput("flAr_rready", rready_o, 1);
    checkOutput("flAr_readyPre", ready_pre_o, 0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checkOutput("flAr_stillDraining", rready_o, 1);
    checkOutput("flAr_readyPreDrain", ready_pre_o, 0);
    rvalid_i = 1'b1;
    rdata_i  = 32'h1234_5678;
    tick();
    rvalid_i = 1'b0;
    checkOutput("flAr_validPostDrained", valid_post_o, 0);
    checkOutput("flAr_rreadyDrained", rready_o, 0);
    checkOutput("flAr_idle", ready_pre_o, 1);

    // Error response substitutes the NOP.
    $display("[TB] error response");
    applyStimulus(32'h8000_000C, 32'hDEAD_BEEF, 2'b10);
    checkDelivery("err");
    acceptDelivery("err");

    // Flush coincident with the read beat: response dropped.
    $display("[TB] flush with read beat");
    valid_pre_i = 1'b1;
    pc_i        = 32'h8000_0010;
    tick();
    valid_pre_i = 1'b0;
    arready_i   = 1'b1;
    tick();
    arready_i = 1'b0;
    rvalid_i  = 1'b1;
    rdata_i   = 32'hAAAA_5555;
    flush_i   = 1'b1;
    tick();
    rvalid_i = 1'b0;
    flush_i  = 1'b0;
    checkOutput("flR_validPost", valid_post_o, 0);
    checkOutput("flR_idle", ready_pre_o, 1);

    // Flush coincident with decode accept: no delivery counted, no stall.
    $display("[TB] flush with decode accept");
    applyStimulus(32'h8000_0014, 32'h0030_0193, 2'b00);
    void'(sb.pop_back());
    checkOutput("flW_validBefore", valid_post_o, 1);
    flush_i      = 1'b1;
    ready_post_i = 1'b1;
    tick();
    flush_i      = 1'b0;
    ready_post_i = 1'b0;
    checkOutput("flW_validPost", valid_post_o, 0);
    checkOutput("flW_idle", ready_pre_o, 1);

    // Upstream handshake under flush is ignored.
    valid_pre_i = 1'b1;
    pc_i        = 32'h8000_0018;
    flush_i     = 1'b1;
    tick();
    valid_pre_i = 1'b0;
    flush_i     = 1'b0;
    checkOutput("flI_arvalid", arvalid_o, 0);
    checkOutput("flI_idle", ready_pre_o, 1);

    // Reset in WAIT_R, then a clean fetch.
    $display("[TB] reset mid-transaction");
    valid_pre_i = 1'b1;
    pc_i        = 32'h8000_0020;
    tick();
    valid_pre_i = 1'b0;
    arready_i   = 1'b1;
    tick();
    arready_i = 1'b0;
    checkOutput("rstR_inWaitR", rready_o, 1);
    reset = 1'b1;
    tick();
    checkOutput("rstR_rready", rready_o, 0);
    checkOutput("rstR_arvalid", arvalid_o, 0);
    checkOutput("rstR_validPost", valid_post_o, 0);
    checkOutput("rstR_pc", pc_o, 0);
    checkOutput("rstR_inst", inst_o, 0);
    checkOutput("rstR_err", inst_err_o, 0);
    reset = 1'b0;
    tick();
    checkOutput("rstR_readyPre", ready_pre_o, 1);
    applyStimulus(32'h8000_0004, 32'h0040_0213, 2'b00);
    checkDelivery("post");
    acceptDelivery("post");

    checkOutput("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
